alu_exec: RTL and testbench

Pipelined two-stage integer ALU that consumes the 4-bit `alu_c` operation code produced by the ALU control decoder and executes it on two operands. It sits between register-read and writeback in the pipelined core variant. It accepts one operation per cycle over a valid/ready handshake and returns a registered result with zero and overflow flags. Codes outside the defined set are flagged as illegal rather than silently executed.

---
 rtl/alu_exec.sv | 136 +++++++++++++
 tb/tb_alu_exec.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: two-stage pipelined integer ALU with a valid/ready handshake.
// Stage 1 registers the opcode and operands; stage 2 computes and registers
// result, zero, ovf and illegal. Backpressure from out_ready stalls both stages.
// Optional feature macro: ALU_EXEC_OVF_EN enables the signed-overflow flag
// for ADD/SUB. Without it ovf is a constant 0 (SLT still corrects internally).
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_c,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;

    logic             s1_v;
    logic             s2_v;
    logic             s2_adv;
    logic             load_s2;
    logic [3:0]       s1_c;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic             lt;
    logic [WIDTH-1:0] res_c;
    logic             illegal_c;

    // Stage 2 may take new data when it is empty or being drained this cycle.
    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign load_s2   = s2_adv && s1_v;
    assign out_valid = s2_v;

    // Valid bits for both stages; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (in_ready) s1_v <= in_valid;
            if (s2_adv)   s2_v <= s1_v;
        end
    end

    // Stage 1 operand capture; contents are meaningless while s1_v is low.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_c <= alu_c;
            s1_a <= src_a;
            s1_b <= src_b;
        end
    end

    // Arithmetic shared by ADD/SUB/SLT; SLT uses the overflow-corrected sign.
    always_comb begin
        sum     = s1_a + s1_b;
        diff    = s1_a - s1_b;
        sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
        lt      = diff[WIDTH-1] ^ sub_ovf;
    end

    // Opcode decode; undefined codes produce a zero result and the illegal flag.
    always_comb begin
        res_c     = '0;
        illegal_c = 1'b0;
        case (s1_c)
            OP_AND:  res_c = s1_a & s1_b;
            OP_OR:   res_c = s1_a | s1_b;
            OP_XOR:  res_c = s1_a ^ s1_b;
            OP_NOR:  res_c = ~(s1_a | s1_b);
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, lt};
            OP_NAND: res_c = ~(s1_a & s1_b);
            OP_ADD:  res_c = sum;
            OP_SUB:  res_c = diff;
            default: illegal_c = 1'b1;
        endcase
    end

    // Stage 2 result registers; held while the consumer stalls or the pipe is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (load_s2) begin
            result  <= res_c;
            zero    <= (res_c == '0);
            illegal <= illegal_c;
        end
    end

`ifdef ALU_EXEC_OVF_EN
    logic add_ovf;
    logic ovf_c;
    logic ovf_q;

    // Signed overflow is only meaningful for ADD and SUB.
    always_comb begin
        add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        ovf_c   = 1'b0;
        if (s1_c == OP_ADD) ovf_c = add_ovf;
        if (s1_c == OP_SUB) ovf_c = sub_ovf;
    end

    // Overflow flag register, loaded alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_q <= 1'b0;
        else if (load_s2) ovf_q <= ovf_c;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, backpressure and
// reset sequences, then randomized traffic against a count/queue reference.
module tb_alu_exec;

    localparam int WIDTH = 32;
`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_c;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_c     (alu_c),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;
    exp_t q[$];
    logic hold_pending = 1'b0;
    logic [31:0] held_res;
    logic held_z, held_o, held_il;
    logic last_in_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model from the opcode definitions using wide signed arithmetic.
    function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'h0; e.o = 1'b0; e.il = 1'b0;
        case (c)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = a ^ b;
            4'd3: e.res = ~(a | b);
            4'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: e.res = ~(a & b);
            4'd8: begin
                wide  = sa + sb;
                e.res = a + b;
                e.o   = OVF_ON && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            4'd9: begin
                wide  = sa - sb;
                e.res = a - b;
                e.o   = OVF_ON && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    // One handshake cycle: drive at negedge, check, then update the scoreboard.
    task automatic cycle(input logic iv, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, output logic took);
        exp_t e;
        @(negedge clk);
        in_valid = iv; alu_c = c; src_a = a; src_b = b; out_ready = ordy;
        #1;
        last_in_ready = in_ready;
        check("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !ordy)});
        if (hold_pending) begin
            check("hold_result", result, held_res);
            check("hold_flags", {29'b0, zero, ovf, illegal}, {29'b0, held_z, held_o, held_il});
        end
        if (q.size() == 0) check("idle_out_valid", {31'b0, out_valid}, 32'd0);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_output", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                n_popped++;
                check("stream_result", result, e.res);
                check("stream_flags", {29'b0, zero, ovf, illegal}, {29'b0, e.z, e.o, e.il});
            end
        end
        hold_pending = out_valid && !out_ready;
        held_res = result; held_z = zero; held_o = ovf; held_il = illegal;
        took = iv && in_ready;
        if (took) q.push_back(ref_alu(c, a, b));
    endtask

    // Single operation into an empty pipe, checking 2-cycle latency and the values.
    task automatic run_single(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1; alu_c = v.code; src_a = v.a; src_b = v.b; out_ready = 1'b1;
        #1 check({v.name, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({v.name, "_lat1"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({v.name, "_lat2"}, {31'b0, out_valid}, 32'd1);
        check({v.name, "_result"}, result, v.res);
        check({v.name, "_flags"}, {29'b0, zero, ovf, illegal}, {29'b0, v.z, v.o, v.il});
        @(posedge clk); #1;
    endtask

    vec_t vecs[$];
    logic took;
    int   sent;
    int   pop0;
    logic saw_block;
    logic [31:0] pick_a, pick_b;
    logic [31:0] corners [6];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{"add_ovf", 4'b1000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, OVF_ON, 1'b0});
        vecs.push_back('{"sub_zero", 4'b1001, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"xor", 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"nor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"nand", 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"slt_min", 4'b0100, 32'h80000000, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"slt_max", 4'b0100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"slt_eq", 4'b0100, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ill_0110", 4'b0110, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ill_1111", 4'b1111, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"after_ill", 4'b1000, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf", 4'b1001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, OVF_ON, 1'b0});

        rst_n = 1'b0; in_valid = 1'b0; alu_c = 4'h0; src_a = '0; src_b = '0; out_ready = 1'b1;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_outputs", {result[30:0], zero, ovf, illegal} | {31'b0, |result}, 34'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        #22 rst_n = 1'b1;

        foreach (vecs[i]) run_single(vecs[i]);

        // Backpressure: four ADDs with out_ready low for three cycles mid-stream.
        sent = 0; pop0 = n_popped; saw_block = 1'b0; hold_pending = 1'b0;
        for (int cyc = 0; cyc < 30 && (sent < 4 || q.size() > 0); cyc++) begin
            cycle(sent < 4, 4'b1000, sent, 32'd1, !(cyc >= 2 && cyc < 5), took);
            if (took) sent++;
            if (!last_in_ready) saw_block = 1'b1;
        end
        check("bp_sent", sent, 32'd4);
        check("bp_received", n_popped - pop0, 32'd4);
        check("bp_in_ready_dropped", {31'b0, saw_block}, 32'd1);
        check("bp_queue_empty", q.size(), 32'd0);

        // Reset with both stages full.
        cycle(1'b1, 4'b1000, 32'd10, 32'd20, 1'b0, took);
        cycle(1'b1, 4'b1001, 32'd10, 32'd20, 1'b0, took);
        check("fill_depth", q.size(), 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_reset_result", result, 32'h0);
        check("mid_reset_flags", {29'b0, zero, ovf, illegal}, 32'd0);
        q.delete(); hold_pending = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_single('{"post_reset", 4'b1000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, OVF_ON, 1'b0});

        // Randomized traffic with random backpressure.
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h5A5A5A5A};
        for (int n = 0; n < 400; n++) begin
            pick_a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            pick_b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), pick_a, pick_b,
                  $urandom_range(0, 9) < 7, took);
        end
        for (int n = 0; n < 10 && q.size() > 0; n++)
            cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, took);
        check("drain_queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
